bus_responder: RTL and testbench
================================

Name: bus_responder

Overview:
- Target end of the CPU memory bus. Serves the CPU's `we`/`addr`/`data` requests from word RAM and a small MMIO register block.
- RAM region: single-port word array; MMIO region: LED register, 64-bit cycle counter, timer compare, sticky status.
- Sits at top level beside `cpu`: CPU `addr_o`/`we_o`/`data_o` drive this block, and this block's `data_o` drives CPU `data_i`.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words (power of two).
- MMIO_BASE, 32'hFFFF_0000, byte address of MMIO region (64 KiB window, upper 16 bits compared).
- ROM_WORDS, 256, words from address 0 treated read-only when WRITE_PROTECT_EN defined.

Ports:
- clk, input, 1, system clock, all logic on rising edge.
- reset, input, 1, synchronous active-low reset.
- we_i, input, 1, write strobe from CPU, sampled each rising edge.
- addr_i, input, 32, byte address; bits [1:0] ignored.
- data_i, input, 32, write data from CPU.
- data_o, output, 32, registered read data to CPU.
- led_o, output, 8, LED register contents.
- irq_o, output, 1, equals STATUS.timer_hit.
- bus_err_o, output, 1, equals STATUS.bus_err.

Behaviour:
- One clock; reset is synchronous and active-low. reset==0 at a rising edge clears: data_o=0, led_o=0, counter=0, cnt_hi_snap=0, TIMER_CMP=0, STATUS=0. RAM contents are not reset.
- Decode is a 3-way priority:
  - MMIO if addr_i[31:16]==MMIO_BASE[31:16].
  - Else RAM if addr_i[31:2] < MEM_WORDS.
  - Else unmapped.
- RAM index = addr_i[log2(MEM_WORDS)+1:2].
- Transfers occur every cycle; there is no handshake.
  - Read: data_o updates on the edge after addr_i is presented (1-cycle latency).
  - Write: when we_i=1, the write commits at the same edge.
- Read-during-write on the same cycle is write-first: data_o = data_i.
- MMIO map, byte offsets:
  - 0x00 LED: RW; bits [7:0] stored, upper bits read 0.
  - 0x04 CNT_LO: RO; reading returns counter[31:0] and loads cnt_hi_snap with counter[63:32] of the same cycle.
  - 0x08 CNT_HI: RO; returns cnt_hi_snap.
  - 0x0C TIMER_CMP: RW, 32 bits.
  - 0x10 STATUS: bit0 timer_hit, bit1 bus_err; write-1-to-clear; other bits read 0.
  - Other offsets read 0; writes to them are ignored, no error.
- Counter: 64-bit, increments every non-reset cycle, wraps 2^64-1 -> 0.
- timer_hit:
  - Set when TIMER_CMP!=0 and counter[31:0]==TIMER_CMP.
  - If set and W1C occur in the same cycle, set wins.
- Unmapped access:
  - Read returns 32'hDEAD_BEEF.
  - Read or write sets bus_err; a write does not change state.
  - If bus_err set and W1C occur in the same cycle, set wins.
- Writes to RO registers (CNT_LO, CNT_HI) are ignored, no error.
- Reset asserted mid-sequence: the write presented that cycle is dropped and all registers take reset values.

Optional Feature:
- WRITE_PROTECT_EN:
  - Defined: RAM words [0, ROM_WORDS) ignore writes and the attempt sets bus_err. Reads are unaffected, and data_o shows stored (old) data, not write-first.
  - Undefined: the whole RAM is writable and ROM_WORDS is unused.

Test Plan:
- Write 32'hCAFE_0001 to 0x0000_0400, then read 0x400 -> data_o = 32'hCAFE_0001 one cycle after address; addr 0x401 reads the same word.
- Write 32'h1234_5678 to 0x8 with we_i=1 and same addr -> data_o = 32'h1234_5678 on the same edge (write-first); a following read also returns it.
- Release reset, wait 100 cycles, read CNT_LO then CNT_HI -> CNT_LO = cycle count ±1 consistent with the bench counter; CNT_HI = 0. Force counter to 0x0000_0000_FFFF_FFFF, read CNT_LO -> 0; CNT_HI -> 1.
- Write TIMER_CMP = 50 just after reset -> irq_o rises the cycle after counter[31:0]==50. Write STATUS=1 -> irq_o=0. Clear on the exact hit cycle -> irq_o stays 1.
- Read 0x0010_0000 (MEM_WORDS=1024) -> data_o = 32'hDEAD_BEEF and bus_err_o=1. Write STATUS=2 -> bus_err_o=0. Write LED=32'h1A5 -> led_o=8'hA5; LED reads back 32'h0000_00A5.
- WRITE_PROTECT_EN defined: write 32'hFFFF_FFFF to 0x0, read 0x0 -> prior contents and bus_err_o=1. Write to word 256 succeeds. Assert reset -> led_o, irq_o, bus_err_o, data_o all 0.

Source files
------------

// File: rtl/bus_responder.sv
// bus_responder: target end of the CPU memory bus.
// Serves single-cycle reads/writes from a word RAM and a small MMIO block
// (LED, 64-bit cycle counter, timer compare, sticky status).
// Every cycle is a transfer: the address and write strobe are sampled on each
// rising edge, writes commit on that edge, and read data appears on data_o
// after that edge. There is no valid/ready handshake.
// Optional feature macro: WRITE_PROTECT_EN. When defined, RAM words
// [0, ROM_WORDS) ignore writes and flag bus_err.
module bus_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int unsigned ROM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [7:0]  led_o,
    output logic        irq_o,
    output logic        bus_err_o
);

    localparam int unsigned AW            = $clog2(MEM_WORDS);
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    // MMIO word offsets (byte offset >> 2)
    localparam logic [13:0] OFF_LED    = 14'd0;
    localparam logic [13:0] OFF_CNT_LO = 14'd1;
    localparam logic [13:0] OFF_CNT_HI = 14'd2;
    localparam logic [13:0] OFF_TIMER  = 14'd3;
    localparam logic [13:0] OFF_STATUS = 14'd4;

    logic [31:0] mem_q [MEM_WORDS];

    logic [31:0] data_q, data_d;
    logic [7:0]  led_q, led_d;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] cnt_hi_snap_q, cnt_hi_snap_d;
    logic [31:0] timer_cmp_q, timer_cmp_d;
    logic        timer_hit_q, timer_hit_d;
    logic        bus_err_q, bus_err_d;

    logic          is_mmio;
    logic          is_ram;
    logic [AW-1:0] ram_idx;
    logic [13:0]   mmio_off;
    logic          wp_block;
    logic          ram_wr;
    logic          hit_set;
    logic          hit_clr;
    logic          err_set;
    logic          err_clr;
    logic          unused_addr_bits;

    // Address decode: MMIO window has priority over RAM; everything else is unmapped.
    assign is_mmio  = (addr_i[31:16] == MMIO_BASE[31:16]);
    assign is_ram   = !is_mmio && ({2'b00, addr_i[31:2]} < MEM_WORDS);
    assign ram_idx  = addr_i[AW+1:2];
    assign mmio_off = addr_i[15:2];

    // Byte lane bits play no part in a word-addressed bus.
    assign unused_addr_bits = ^addr_i[1:0];

`ifdef WRITE_PROTECT_EN
    // Low RAM words behave as ROM: the write is refused and reported.
    assign wp_block = is_ram && we_i && (32'(ram_idx) < ROM_WORDS);
`else
    logic unused_rom_words;
    assign wp_block         = 1'b0;
    assign unused_rom_words = (ROM_WORDS != 0);
`endif

    assign ram_wr = we_i && is_ram && !wp_block;

    // Next-state for read data, MMIO registers, counter and sticky status.
    always_comb begin
        data_d        = 32'h0;
        led_d         = led_q;
        cnt_d         = cnt_q + 64'd1;
        cnt_hi_snap_d = cnt_hi_snap_q;
        timer_cmp_d   = timer_cmp_q;
        err_set       = 1'b0;
        hit_clr       = 1'b0;
        err_clr       = 1'b0;

        if (is_mmio) begin
            case (mmio_off)
                OFF_LED: begin
                    data_d = {24'h0, led_q};
                    if (we_i) led_d = data_i[7:0];
                end
                OFF_CNT_LO: begin
                    // Snapshot the high half so a following CNT_HI read is coherent.
                    data_d = cnt_q[31:0];
                    if (!we_i) cnt_hi_snap_d = cnt_q[63:32];
                end
                OFF_CNT_HI: data_d = cnt_hi_snap_q;
                OFF_TIMER: begin
                    data_d = timer_cmp_q;
                    if (we_i) timer_cmp_d = data_i;
                end
                OFF_STATUS: begin
                    data_d = {30'h0, bus_err_q, timer_hit_q};
                    if (we_i) begin
                        hit_clr = data_i[0];
                        err_clr = data_i[1];
                    end
                end
                default: data_d = 32'h0;
            endcase
        end else if (is_ram) begin
            // Write-first on a committed write; a refused write shows stored data.
            if (ram_wr) data_d = data_i;
            else        data_d = mem_q[ram_idx];
            if (wp_block) err_set = 1'b1;
        end else begin
            data_d  = UNMAPPED_DATA;
            err_set = 1'b1;
        end

        // Sticky flags: a set event in the same cycle as a clear wins.
        hit_set     = (timer_cmp_q != 32'h0) && (cnt_q[31:0] == timer_cmp_q);
        timer_hit_d = hit_set || (timer_hit_q && !hit_clr);
        bus_err_d   = err_set || (bus_err_q && !err_clr);
    end

    // Register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q        <= 32'h0;
            led_q         <= 8'h0;
            cnt_q         <= 64'h0;
            cnt_hi_snap_q <= 32'h0;
            timer_cmp_q   <= 32'h0;
            timer_hit_q   <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            data_q        <= data_d;
            led_q         <= led_d;
            cnt_q         <= cnt_d;
            cnt_hi_snap_q <= cnt_hi_snap_d;
            timer_cmp_q   <= timer_cmp_d;
            timer_hit_q   <= timer_hit_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // RAM write port; contents survive reset but a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && ram_wr) begin
            mem_q[ram_idx] <= data_i;
        end
    end

    assign data_o    = data_q;
    assign led_o     = led_q;
    assign irq_o     = timer_hit_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a vector table for single-cycle
// RAM/MMIO accesses, then hand sequences for the counter, reset and timer.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [7:0]  led_o;
    logic        irq_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench model of the cycle counter: zero under reset, +1 per other edge.
    logic [63:0] cyc;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] exp_data;
        logic [7:0]  exp_led;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .led_o     (led_o),
        .irq_o     (irq_o),
        .bus_err_o (bus_err_o)
    );

    // Clock and counter model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) cyc <= 64'h0;
        else        cyc <= cyc + 64'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        we_i   = we;
        addr_i = addr;
        data_i = data;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic chk, input logic [31:0] exp_data,
                       input logic [7:0] exp_led, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.data = data;
        v.chk_data = chk; v.exp_data = exp_data; v.exp_led = exp_led; v.exp_err = exp_err;
        vq.push_back(v);
    endtask

    initial begin
        logic [63:0] exp_cnt;
        logic [63:0] target;

        // Reset state
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        check32("reset_data", data_o, 32'h0);
        check32("reset_led", {24'h0, led_o}, 32'h0);
        check32("reset_irq", {31'h0, irq_o}, 32'h0);
        check32("reset_err", {31'h0, bus_err_o}, 32'h0);
        reset = 1'b1;

        // Vector table: name, we, addr, data, chk_data, exp_data, exp_led, exp_err
        add("ram_wr_400",     1, 32'h0000_0400, 32'hCAFE_0001, 1, 32'hCAFE_0001, 8'h00, 0);
        add("ram_rd_400",     0, 32'h0000_0400, 32'h0,         1, 32'hCAFE_0001, 8'h00, 0);
        add("ram_rd_401",     0, 32'h0000_0401, 32'h0,         1, 32'hCAFE_0001, 8'h00, 0);
`ifndef WRITE_PROTECT_EN
        add("ram_wr_first_8", 1, 32'h0000_0008, 32'h1234_5678, 1, 32'h1234_5678, 8'h00, 0);
        add("ram_rd_8",       0, 32'h0000_0008, 32'h0,         1, 32'h1234_5678, 8'h00, 0);
`endif
        add("ram_wr_last",    1, 32'h0000_0FFC, 32'hA5A5_0FFC, 1, 32'hA5A5_0FFC, 8'h00, 0);
        add("ram_rd_last",    0, 32'h0000_0FFC, 32'h0,         1, 32'hA5A5_0FFC, 8'h00, 0);
        add("unmapped_rd",    0, 32'h0010_0000, 32'h0,         1, 32'hDEAD_BEEF, 8'h00, 1);
        add("status_w1c_err", 1, 32'hFFFF_0010, 32'h2,         0, 32'h0,         8'h00, 0);
        add("led_wr",         1, 32'hFFFF_0000, 32'h0000_01A5, 0, 32'h0,         8'hA5, 0);
        add("led_rd",         0, 32'hFFFF_0000, 32'h0,         1, 32'h0000_00A5, 8'hA5, 0);
        add("unmapped_wr",    1, 32'h0000_1400, 32'hBAD0_BAD0, 0, 32'h0,         8'hA5, 1);
        add("ram_no_alias",   0, 32'h0000_0400, 32'h0,         1, 32'hCAFE_0001, 8'hA5, 1);
        add("status_rd_err",  0, 32'hFFFF_0010, 32'h0,         1, 32'h0000_0002, 8'hA5, 1);
        add("status_clr2",    1, 32'hFFFF_0010, 32'h2,         0, 32'h0,         8'hA5, 0);
        add("cnt_lo_wr_ro",   1, 32'hFFFF_0004, 32'hFFFF_FFFF, 0, 32'h0,         8'hA5, 0);
        add("other_off_wr",   1, 32'hFFFF_0014, 32'h1,         0, 32'h0,         8'hA5, 0);
        add("other_off_rd",   0, 32'hFFFF_0014, 32'h0,         1, 32'h0,         8'hA5, 0);
        add("timer_cmp_rd0",  0, 32'hFFFF_000C, 32'h0,         1, 32'h0,         8'hA5, 0);
        add("past_ram_rd",    0, 32'h0000_1000, 32'h0,         1, 32'hDEAD_BEEF, 8'hA5, 1);
        add("status_clr3",    1, 32'hFFFF_0010, 32'h2,         0, 32'h0,         8'hA5, 0);

        foreach (vq[i]) begin
            drive(vq[i].we, vq[i].addr, vq[i].data);
            tick();
            if (vq[i].chk_data) check32({vq[i].name, "_data"}, data_o, vq[i].exp_data);
            check32({vq[i].name, "_led"}, {24'h0, led_o}, {24'h0, vq[i].exp_led});
            check32({vq[i].name, "_err"}, {31'h0, bus_err_o}, {31'h0, vq[i].exp_err});
            check32({vq[i].name, "_irq"}, {31'h0, irq_o}, 32'h0);
        end

`ifdef WRITE_PROTECT_EN
        // Protected low RAM: write refused and flagged, stored data unchanged
        drive(1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        tick();
        check32("wp_err", {31'h0, bus_err_o}, 32'h1);
        drive(1'b0, 32'h0000_0000, 32'h0);
        tick();
        n_checks++;
        if (data_o === 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wp_rd: got %08h required stored data other than ffffffff", data_o);
        end
        drive(1'b1, 32'hFFFF_0010, 32'h2);
        tick();
`endif

        // Counter after ~100 idle cycles; CNT_HI returns the snapshot
        drive(1'b0, 32'hFFFF_0014, 32'h0);
        repeat (100) tick();
        drive(1'b0, 32'hFFFF_0004, 32'h0);
        exp_cnt = cyc;
        tick();
        check32("cnt_lo", data_o, exp_cnt[31:0]);
        drive(1'b0, 32'hFFFF_0008, 32'h0);
        tick();
        check32("cnt_hi", data_o, exp_cnt[63:32]);

        // Carry into the high half
        drive(1'b0, 32'hFFFF_0014, 32'h0);
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cnt_q;
        tick();
        drive(1'b0, 32'hFFFF_0004, 32'h0);
        tick();
        check32("cnt_lo_wrap", data_o, 32'h0);
        drive(1'b0, 32'hFFFF_0008, 32'h0);
        tick();
        check32("cnt_hi_carry", data_o, 32'h1);

        // Reset mid-sequence: write dropped, registers cleared
        drive(1'b0, 32'h0010_0000, 32'h0);
        tick();
        check32("pre_reset_err", {31'h0, bus_err_o}, 32'h1);
        reset = 1'b0;
        drive(1'b1, 32'h0000_0400, 32'h0BAD_F00D);
        tick();
        check32("mid_reset_data", data_o, 32'h0);
        check32("mid_reset_led", {24'h0, led_o}, 32'h0);
        check32("mid_reset_irq", {31'h0, irq_o}, 32'h0);
        check32("mid_reset_err", {31'h0, bus_err_o}, 32'h0);

        // Leave reset while programming TIMER_CMP = 50
        reset = 1'b1;
        drive(1'b1, 32'hFFFF_000C, 32'd50);
        tick();
        check32("cmp_zero_no_hit", {31'h0, irq_o}, 32'h0);
        drive(1'b0, 32'h0000_0400, 32'h0);
        tick();
        check32("reset_write_dropped", data_o, 32'hCAFE_0001);

        drive(1'b0, 32'hFFFF_0014, 32'h0);
        for (int i = 0; i < 200 && cyc != 64'd50; i++) tick();
        check32("timer_wait", cyc[31:0], 32'd50);
        check32("irq_before_hit", {31'h0, irq_o}, 32'h0);
        tick();
        check32("irq_on_hit", {31'h0, irq_o}, 32'h1);
        drive(1'b1, 32'hFFFF_0010, 32'h1);
        tick();
        check32("irq_cleared", {31'h0, irq_o}, 32'h0);

        // Clear on the exact hit cycle: set wins
        target = cyc + 64'd8;
        drive(1'b1, 32'hFFFF_000C, target[31:0]);
        tick();
        drive(1'b0, 32'hFFFF_000C, 32'h0);
        tick();
        check32("timer_cmp_rd", data_o, target[31:0]);
        drive(1'b0, 32'hFFFF_0014, 32'h0);
        for (int i = 0; i < 50 && cyc != target; i++) tick();
        check32("hit2_wait", cyc[31:0], target[31:0]);
        drive(1'b1, 32'hFFFF_0010, 32'h1);
        tick();
        check32("irq_set_wins", {31'h0, irq_o}, 32'h1);
        drive(1'b1, 32'hFFFF_0010, 32'h1);
        tick();
        check32("irq_cleared2", {31'h0, irq_o}, 32'h0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
